// File: rtl/peribus_bridge.sv
// Purpose: single-master bridge from the CPU valid/ready load/store port to Peribus chipselect/strobe signals.
// Latency: request accept to resp_valid is 2 cycles (write), 2+READ_LATENCY (read), 1 (unmapped).
// Backpressure: one transaction in flight, req_ready only in IDLE; response held until resp_ready.
// Optional build macro PERIBUS_IRQ_EN: slave index 15 becomes internal irq status/mask registers, adds irq_in/irq_out.
module peribus_bridge #(
    parameter int          NUM_SLAVES   = 4,
    parameter int          READ_LATENCY = 1,
    parameter logic [7:0]  PERIPH_PAGE  = 8'hFF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [15:0]               req_addr,
    input  logic [15:0]               req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [15:0]               resp_rdata,
    output logic                      resp_err,
    output logic [1:0]                pb_addr,
    output logic [15:0]               pb_write_data,
    output logic                      pb_write_en,
    output logic                      pb_read_en,
    output logic [NUM_SLAVES-1:0]     pb_chipselect,
    input  logic [16*NUM_SLAVES-1:0]  pb_read_data
`ifdef PERIBUS_IRQ_EN
    ,
    input  logic [NUM_SLAVES-1:0]     irq_in,
    output logic                      irq_out
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, STROBE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    localparam logic [4:0] NUM_SLAVES_W = 5'(NUM_SLAVES);
    localparam logic [2:0] WAIT_LOAD    = 3'(READ_LATENCY - 1);

    state_t                  state, state_n;
    logic                    write_q, internal_q;
    logic [3:0]              idx_q;
    logic [2:0]              wait_cnt;
    logic                    req_fire, page_hit, slave_hit, internal_hit;
    logic                    cur_write, cur_internal;
    logic [3:0]              req_idx, cur_idx;
    logic [NUM_SLAVES-1:0]   sel_onehot, cs_d;
    logic [15:0]             slave_rdata, internal_rdata, rdata_d, wdata_d;
    logic [1:0]              addr_d;
    logic                    err_d, we_d, re_d;
    logic                    addr_unused;

    // Address bits [7:6] carry no meaning on the peripheral page.
    assign addr_unused = ^req_addr[7:6];

    assign req_ready    = (state == IDLE);
    assign req_fire     = req_valid & req_ready;
    assign req_idx      = req_addr[5:2];
    assign page_hit     = (req_addr[15:8] == PERIPH_PAGE);
    assign slave_hit    = page_hit && ({1'b0, req_idx} < NUM_SLAVES_W);
    assign cur_idx      = (state == IDLE) ? req_idx : idx_q;
    assign cur_write    = (state == IDLE) ? req_write : write_q;
    assign cur_internal = (state == IDLE) ? internal_hit : internal_q;

`ifdef PERIBUS_IRQ_EN
    logic [1:0]            reg_q;
    logic [NUM_SLAVES-1:0] irq_status, irq_mask;

    assign internal_hit = page_hit && (req_idx == 4'hF);

    // Internal register file: synchronized irq status, mask, and the registered irq output.
    always_ff @(posedge clock) begin
        if (reset) begin
            reg_q      <= '0;
            irq_status <= '0;
            irq_mask   <= '0;
            irq_out    <= 1'b0;
        end else begin
            irq_status <= irq_in;
            irq_out    <= |(irq_status & irq_mask);
            if (req_fire)
                reg_q <= req_addr[1:0];
            if (req_fire && internal_hit && req_write && req_addr[1:0] == 2'd1)
                irq_mask <= req_wdata[NUM_SLAVES-1:0];
        end
    end

    // Internal register read mux.
    always_comb begin
        internal_rdata = '0;
        case (reg_q)
            2'd0:    internal_rdata = 16'(irq_status);
            2'd1:    internal_rdata = 16'(irq_mask);
            default: internal_rdata = '0;
        endcase
    end
`else
    assign internal_hit   = 1'b0;
    assign internal_rdata = '0;
`endif

    // One-hot select and read-data slice for the addressed slave.
    always_comb begin
        sel_onehot  = '0;
        slave_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (cur_idx == 4'(k))
                sel_onehot[k] = 1'b1;
            if (idx_q == 4'(k))
                slave_rdata = pb_read_data[16*k +: 16];
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_fire) state_n = (slave_hit || internal_hit) ? STROBE : RESP;
            STROBE:  state_n = (write_q || internal_q) ? RESP : WAIT;
            WAIT:    if (wait_cnt == 3'd0) state_n = RESP;
            RESP:    if (resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered.
    always_comb begin
        cs_d    = '0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        addr_d  = pb_addr;
        wdata_d = pb_write_data;
        rdata_d = resp_rdata;
        err_d   = resp_err;
        if ((state_n == STROBE || state_n == WAIT) && !cur_internal)
            cs_d = sel_onehot;
        if (state_n == STROBE && !cur_internal) begin
            we_d = cur_write;
            re_d = !cur_write;
        end
        case (state)
            IDLE: begin
                if (req_fire) begin
                    if (slave_hit) begin
                        addr_d  = req_addr[1:0];
                        wdata_d = req_wdata;
                    end else if (!internal_hit) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            STROBE: begin
                err_d = 1'b0;
                if (internal_q)
                    rdata_d = write_q ? 16'h0000 : internal_rdata;
                else if (write_q)
                    rdata_d = '0;
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    rdata_d = slave_rdata;
                    err_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output registers, request latch and read-latency counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            pb_addr       <= '0;
            pb_write_data <= '0;
            pb_write_en   <= 1'b0;
            pb_read_en    <= 1'b0;
            pb_chipselect <= '0;
            write_q       <= 1'b0;
            internal_q    <= 1'b0;
            idx_q         <= '0;
            wait_cnt      <= '0;
        end else begin
            resp_valid    <= (state_n == RESP);
            resp_rdata    <= rdata_d;
            resp_err      <= err_d;
            pb_addr       <= addr_d;
            pb_write_data <= wdata_d;
            pb_write_en   <= we_d;
            pb_read_en    <= re_d;
            pb_chipselect <= cs_d;
            if (req_fire) begin
                write_q    <= req_write;
                internal_q <= internal_hit;
                idx_q      <= req_idx;
            end
            if (state == STROBE)
                wait_cnt <= WAIT_LOAD;
            else if (state == WAIT && wait_cnt != 3'd0)
                wait_cnt <= wait_cnt - 3'd1;
        end
    end

endmodule

// File: tb/tb_peribus_bridge.sv
// Purpose: directed-vector bench for peribus_bridge with a response scoreboard and cycle-level strobe checks.
// Latency: a READ_LATENCY=1 instance carries most tests, a READ_LATENCY=4 instance covers long reads and reset mid-read.
// Backpressure: resp_ready held low to check response hold and request blocking.
module tb_peribus_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_write, resp_ready;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [15:0] resp_rdata, pb_write_data;
    logic [1:0]  pb_addr;
    logic        pb_write_en, pb_read_en;
    logic [3:0]  pb_chipselect;
    logic [63:0] pb_read_data;
`ifdef PERIBUS_IRQ_EN
    logic [3:0]  irq_in;
    logic        irq_out;
`endif

    logic        reset4, req_valid4, req_write4, resp_ready4;
    logic [15:0] req_addr4, req_wdata4;
    logic        req_ready4, resp_valid4, resp_err4;
    logic [15:0] resp_rdata4, pb_write_data4;
    logic [1:0]  pb_addr4;
    logic        pb_write_en4, pb_read_en4;
    logic [3:0]  pb_chipselect4;
    logic [63:0] pb_read_data4;

    int n_checks = 0;
    int n_fail   = 0;
    logic [16:0] exp_q[$];

    always #5 clock = ~clock;

    peribus_bridge #(.NUM_SLAVES(4), .READ_LATENCY(1), .PERIPH_PAGE(8'hFF)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .pb_addr(pb_addr), .pb_write_data(pb_write_data),
        .pb_write_en(pb_write_en), .pb_read_en(pb_read_en),
        .pb_chipselect(pb_chipselect), .pb_read_data(pb_read_data)
`ifdef PERIBUS_IRQ_EN
        , .irq_in(irq_in), .irq_out(irq_out)
`endif
    );

    peribus_bridge #(.NUM_SLAVES(4), .READ_LATENCY(4), .PERIPH_PAGE(8'hFF)) u_dut4 (
        .clock(clock), .reset(reset4),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_write(req_write4),
        .req_addr(req_addr4), .req_wdata(req_wdata4),
        .resp_valid(resp_valid4), .resp_ready(resp_ready4),
        .resp_rdata(resp_rdata4), .resp_err(resp_err4),
        .pb_addr(pb_addr4), .pb_write_data(pb_write_data4),
        .pb_write_en(pb_write_en4), .pb_read_en(pb_read_en4),
        .pb_chipselect(pb_chipselect4), .pb_read_data(pb_read_data4)
`ifdef PERIBUS_IRQ_EN
        , .irq_in(4'b0000), .irq_out()
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one request in an IDLE cycle, record its expected response, return in cycle 1.
    task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [15:0] exp_rd, input logic exp_err);
        check("accept_ready", 32'(req_ready), 1);
        exp_q.push_back({exp_err, exp_rd});
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    // Response monitor: pops the scoreboard on every completed response handshake.
    always @(negedge clock) begin
        if (reset === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
            check("resp_queue_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0)
                check("resp_err_rdata", 32'({resp_err, resp_rdata}), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; reset4 = 1'b1;
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        req_valid4 = 0; req_write4 = 0; req_addr4 = '0; req_wdata4 = '0; resp_ready4 = 1'b1;
        pb_read_data = '0; pb_read_data4 = '0;
`ifdef PERIBUS_IRQ_EN
        irq_in = '0;
`endif
        repeat (3) tick();

        // Reset state
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_err", 32'(resp_err), 0);
        check("rst_resp_rdata", 32'(resp_rdata), 0);
        check("rst_strobes", 32'({pb_write_en, pb_read_en}), 0);
        check("rst_chipselect", 32'(pb_chipselect), 0);
        check("rst_pb_addr", 32'(pb_addr), 0);
        check("rst_pb_wdata", 32'(pb_write_data), 0);
        reset = 1'b0; reset4 = 1'b0;
        tick();

        // Write 16'hA5A5 to GPIO (slave 1, reg 1)
        issue(1'b1, 16'hFF05, 16'hA5A5, 16'h0000, 1'b0);
        check("wr_cs", 32'(pb_chipselect), 32'h2);
        check("wr_pb_addr", 32'(pb_addr), 1);
        check("wr_we", 32'(pb_write_en), 1);
        check("wr_re", 32'(pb_read_en), 0);
        check("wr_pb_wdata", 32'(pb_write_data), 32'hA5A5);
        check("wr_c1_resp_valid", 32'(resp_valid), 0);
        tick();
        check("wr_c2_resp_valid", 32'(resp_valid), 1);
        check("wr_c2_strobe_off", 32'({pb_write_en, pb_chipselect}), 0);
        tick();

        // Read slave 0 with latency 1
        pb_read_data[15:0]  = 16'h1234;
        pb_read_data[63:48] = 16'hBEEF;
        issue(1'b0, 16'hFF00, 16'h0000, 16'h1234, 1'b0);
        check("rd_re", 32'(pb_read_en), 1);
        check("rd_cs", 32'(pb_chipselect), 32'h1);
        tick();
        check("rd_c2_resp_valid", 32'(resp_valid), 0);
        check("rd_c2_cs_held", 32'(pb_chipselect), 32'h1);
        check("rd_c2_re_off", 32'(pb_read_en), 0);
        tick();
        check("rd_c3_resp_valid", 32'(resp_valid), 1);
        tick();

        // Read slave 3 reg 2
        issue(1'b0, 16'hFF0E, 16'h0000, 16'hBEEF, 1'b0);
        check("rd3_cs", 32'(pb_chipselect), 32'h8);
        check("rd3_pb_addr", 32'(pb_addr), 2);
        tick();
        tick();
        check("rd3_c3_resp_valid", 32'(resp_valid), 1);
        tick();

        // Unmapped: page miss, index beyond NUM_SLAVES
        issue(1'b0, 16'h1F00, 16'h0000, 16'h0000, 1'b1);
        check("unm_page_resp_valid", 32'(resp_valid), 1);
        check("unm_page_no_strobe", 32'({pb_chipselect, pb_write_en, pb_read_en}), 0);
        tick();
        issue(1'b0, 16'hFF10, 16'h0000, 16'h0000, 1'b1);
        check("unm_idx_resp_valid", 32'(resp_valid), 1);
        check("unm_idx_no_strobe", 32'({pb_chipselect, pb_write_en, pb_read_en}), 0);
        tick();

        // Response backpressure on a read from slave 1
        resp_ready = 1'b0;
        pb_read_data[31:16] = 16'h5A5A;
        issue(1'b0, 16'hFF04, 16'h0000, 16'h5A5A, 1'b0);
        tick();
        tick();
        pb_read_data[31:16] = 16'h0000;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'hFF00; req_wdata = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", 32'(resp_valid), 1);
            check("bp_rdata_held", 32'(resp_rdata), 32'h5A5A);
            check("bp_req_ready", 32'(req_ready), 0);
            check("bp_no_strobe", 32'({pb_chipselect, pb_write_en}), 0);
            tick();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        check("bp_after_idle", 32'(req_ready), 1);
        check("bp_stray_ignored", 32'({pb_write_en, pb_chipselect}), 0);

        // Back-to-back writes with resp_ready high: one per 3 cycles
        for (int n = 0; n < 3; n++) exp_q.push_back(17'h0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'hFF08; req_wdata = 16'h1111;
        for (int i = 0; i < 9; i++) begin
            if (i == 7) req_valid = 1'b0;
            check("b2b_req_ready", 32'(req_ready), 32'(i % 3 == 0));
            check("b2b_we", 32'(pb_write_en), 32'(i % 3 == 1));
            tick();
        end

`ifdef PERIBUS_IRQ_EN
        // IRQ: write mask, raise irq_in, read status
        issue(1'b1, 16'hFF3D, 16'h0002, 16'h0000, 1'b0);
        check("irq_wr_no_cs", 32'({pb_chipselect, pb_write_en, pb_read_en}), 0);
        tick();
        check("irq_wr_resp_valid", 32'(resp_valid), 1);
        tick();
        check("irq_out_idle", 32'(irq_out), 0);
        irq_in = 4'b0010;
        tick();
        tick();
        check("irq_out_set", 32'(irq_out), 1);
        issue(1'b0, 16'hFF3C, 16'h0000, 16'h0002, 1'b0);
        tick();
        check("irq_rd_resp_valid", 32'(resp_valid), 1);
        tick();
`else
        // Index 15 is unmapped without the irq block
        issue(1'b0, 16'hFF3C, 16'h0000, 16'h0000, 1'b1);
        check("idx15_resp_valid", 32'(resp_valid), 1);
        tick();
`endif

        // READ_LATENCY=4: full read of slave 1
        pb_read_data4[31:16] = 16'hC0DE;
        req_valid4 = 1'b1; req_write4 = 1'b0; req_addr4 = 16'hFF04;
        tick();
        req_valid4 = 1'b0;
        check("rl4_re", 32'(pb_read_en4), 1);
        check("rl4_we", 32'(pb_write_en4), 0);
        check("rl4_cs", 32'(pb_chipselect4), 32'h2);
        check("rl4_pb_addr", 32'({pb_addr4, pb_write_data4}), 0);
        tick();
        check("rl4_c2_cs", 32'(pb_chipselect4), 32'h2);
        check("rl4_c2_re_off", 32'(pb_read_en4), 0);
        tick(); tick(); tick();
        check("rl4_c5_resp_valid", 32'(resp_valid4), 0);
        tick();
        check("rl4_c6_resp_valid", 32'(resp_valid4), 1);
        check("rl4_c6_rdata", 32'({resp_err4, resp_rdata4}), 32'h0C0DE);
        tick();

        // READ_LATENCY=4: reset during WAIT abandons the read
        req_valid4 = 1'b1;
        tick();
        req_valid4 = 1'b0;
        tick();
        tick();
        check("rst4_in_wait_cs", 32'(pb_chipselect4), 32'h2);
        reset4 = 1'b1;
        tick();
        check("rst4_req_ready", 32'(req_ready4), 1);
        check("rst4_cs", 32'(pb_chipselect4), 0);
        check("rst4_resp_valid", 32'(resp_valid4), 0);
        reset4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst4_no_resp", 32'({resp_valid4, pb_read_en4}), 0);
        end

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
